// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Forwarding / load-use hazard unit for the 5-stage pipeline. It lives in
//   ID and keeps a shadow pipeline of destination tags {RegWr, Rw, MemToReg}
//   for the EX, MEM and WB stages. These tags advance in lockstep with the
//   datapath pipeline registers.
//
//   Build option: define FORWARDING_EN to enable operand forwarding.
//   Without it, the unit is interlock-only: FwdA/FwdB stay at 10, and any
//   EX/MEM producer of a source operand stalls the ID instruction.
//
// Ports
//   Clk          rising-edge clock
//   Reset        synchronous, active-high
//   ID_Rs/ID_Rt  source registers of the ID instruction
//   ID_UseRs/Rt  the ID instruction actually reads that source
//   ID_Rw        destination register of the ID instruction
//   ID_RegWr     the ID instruction writes the register file
//   ID_MemToReg  the ID instruction is a load
//   ID_Flush     kill the ID instruction (a bubble enters EX)
//   Stall        combinational; holds PC and IF/ID, and bubbles EX
//   FwdA/FwdB    registered EXE operand selects
//                (00 MEM_Result, 01 WB_BusW, 10 no forward)
module fwd_hazard_unit #(
  parameter int REG_AW = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [REG_AW-1:0] ID_Rs,
  input  logic [REG_AW-1:0] ID_Rt,
  input  logic              ID_UseRs,
  input  logic              ID_UseRt,
  input  logic [REG_AW-1:0] ID_Rw,
  input  logic              ID_RegWr,
  input  logic              ID_MemToReg,
  input  logic              ID_Flush,
  output logic              Stall,
  output logic [1:0]        FwdA,
  output logic [1:0]        FwdB
);

  localparam logic [1:0] FWD_MEM  = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_NONE = 2'b10;

  // shadow destination tags
  logic              ex_regwr,  mem_regwr,  wb_regwr;
  logic [REG_AW-1:0] ex_rw,     mem_rw,     wb_rw;
  logic              ex_ld,     mem_ld,     wb_ld;

  logic ex_a, ex_b, mem_a, mem_b;
  logic bubble;
  logic [1:0] fwd_a_nxt, fwd_b_nxt;

  // Register 0 is hardwired, so it never creates a dependency.
  assign ex_a  = ex_regwr  && ID_UseRs && (ID_Rs != '0) && (ex_rw  == ID_Rs);
  assign ex_b  = ex_regwr  && ID_UseRt && (ID_Rt != '0) && (ex_rw  == ID_Rt);
  assign mem_a = mem_regwr && ID_UseRs && (ID_Rs != '0) && (mem_rw == ID_Rs);
  assign mem_b = mem_regwr && ID_UseRt && (ID_Rt != '0) && (mem_rw == ID_Rt);

`ifdef FORWARDING_EN
  // Only a load in EX cannot be forwarded in time: its data appears at the
  // end of MEM, one cycle too late for the dependent instruction's EXE.
  assign Stall = ex_ld && (ex_a || ex_b);

  // The EX-tag producer will be in MEM when this instruction reaches EXE,
  // so it takes priority over the older MEM-tag producer.
  always_comb begin
    fwd_a_nxt = FWD_NONE;
    fwd_b_nxt = FWD_NONE;
    if (ex_a)       fwd_a_nxt = FWD_MEM;
    else if (mem_a) fwd_a_nxt = FWD_WB;
    if (ex_b)       fwd_b_nxt = FWD_MEM;
    else if (mem_b) fwd_b_nxt = FWD_WB;
  end
`else
  // Interlock-only: wait until the producer has reached WB. The register
  // file writes before it reads, so that is early enough.
  assign Stall = ex_a || ex_b || mem_a || mem_b;

  always_comb begin
    fwd_a_nxt = FWD_NONE;
    fwd_b_nxt = FWD_NONE;
  end
`endif

  // Stall and Flush both turn the EX slot into a bubble. Stall itself is
  // still reported so that PC and IF/ID hold.
  assign bubble = Stall || ID_Flush;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ex_regwr  <= 1'b0;  ex_rw  <= '0;  ex_ld  <= 1'b0;
      mem_regwr <= 1'b0;  mem_rw <= '0;  mem_ld <= 1'b0;
      wb_regwr  <= 1'b0;  wb_rw  <= '0;  wb_ld  <= 1'b0;
      FwdA      <= FWD_NONE;
      FwdB      <= FWD_NONE;
    end else begin
      wb_regwr  <= mem_regwr;  wb_rw  <= mem_rw;  wb_ld  <= mem_ld;
      mem_regwr <= ex_regwr;   mem_rw <= ex_rw;   mem_ld <= ex_ld;
      if (bubble) begin
        ex_regwr <= 1'b0;
        ex_rw    <= '0;
        ex_ld    <= 1'b0;
        FwdA     <= FWD_NONE;
        FwdB     <= FWD_NONE;
      end else begin
        ex_regwr <= ID_RegWr;
        ex_rw    <= ID_Rw;
        ex_ld    <= ID_MemToReg;
        FwdA     <= fwd_a_nxt;
        FwdB     <= fwd_b_nxt;
      end
    end
  end

  // The WB tag is kept only to mirror the datapath, because the register
  // file's write-before-read already covers that producer. The load flags
  // matter only when forwarding is enabled.
  logic unused_tags;
  assign unused_tags = ^{wb_regwr, wb_rw, wb_ld, mem_ld, ex_ld};

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit
//   Directed-vector bench for fwd_hazard_unit. Each ID-cycle vector carries
//   hand-computed expectations: Stall during that ID cycle, and FwdA/FwdB
//   in the following (EXE) cycle. The vector set follows the FORWARDING_EN
//   build option.
module tb_fwd_hazard_unit;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [4:0] ID_Rs, ID_Rt, ID_Rw;
  logic       ID_UseRs, ID_UseRt, ID_RegWr, ID_MemToReg, ID_Flush;
  logic       Stall;
  logic [1:0] FwdA, FwdB;

  int n_cmp = 0;
  int n_err = 0;

  fwd_hazard_unit #(.REG_AW(5)) dut (
    .Clk(Clk), .Reset(Reset),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
    .ID_Rw(ID_Rw), .ID_RegWr(ID_RegWr), .ID_MemToReg(ID_MemToReg),
    .ID_Flush(ID_Flush), .Stall(Stall), .FwdA(FwdA), .FwdB(FwdB)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // One ID cycle. Drive the inputs at negedge and check Stall. Then, after
  // the next posedge, check the selects registered for this instruction's EXE.
  task automatic ins(input string tag,
                     input logic [4:0] rs, input logic urs,
                     input logic [4:0] rt, input logic urt,
                     input logic [4:0] rw, input logic wr,
                     input logic ld, input logic fl,
                     input logic es, input logic [1:0] efa, input logic [1:0] efb);
    @(negedge Clk);
    ID_Rs = rs; ID_UseRs = urs; ID_Rt = rt; ID_UseRt = urt;
    ID_Rw = rw; ID_RegWr = wr; ID_MemToReg = ld; ID_Flush = fl;
    #1 chk({tag, ".stall"}, int'(Stall), int'(es));
    @(posedge Clk);
    #1;
    chk({tag, ".fwda"}, int'(FwdA), int'(efa));
    chk({tag, ".fwdb"}, int'(FwdB), int'(efb));
  endtask

  task automatic idle(input string tag);
    ins(tag, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10);
  endtask

  // Load r6, then raise Reset while the Rs=r6 consumer sits in ID. After
  // that edge the tags are empty, so the same ID instruction sees no hazard.
  task automatic reset_mid_stall();
    ins("rst.ld6", 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10);
    @(negedge Clk);
    ID_Rs = 5'd6; ID_UseRs = 1'b1; ID_Rw = 5'd0; ID_RegWr = 1'b0;
    ID_MemToReg = 1'b0; Reset = 1'b1;
    #1 chk("rst.stall_before", int'(Stall), 1);
    @(posedge Clk);
    #1;
    chk("rst.stall_after", int'(Stall), 0);
    chk("rst.fwda", int'(FwdA), 2);
    chk("rst.fwdb", int'(FwdB), 2);
    @(negedge Clk);
    Reset = 1'b0;
    ID_Rs = 5'd0; ID_UseRs = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    ID_Rs = '0; ID_Rt = '0; ID_Rw = '0;
    ID_UseRs = 0; ID_UseRt = 0; ID_RegWr = 0; ID_MemToReg = 0; ID_Flush = 0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset.stall", int'(Stall), 0);
    chk("reset.fwda",  int'(FwdA), 2);
    chk("reset.fwdb",  int'(FwdB), 2);
    @(negedge Clk);
    Reset = 1'b0;
    idle("idle0");
    idle("idle1");

`ifdef FORWARDING_EN
    // ALU r5 followed by its consumer: forward from MEM, no stall
    ins("alu5",   0,0, 0,0, 5,1,0,0, 0, 2'b10, 2'b10);
    ins("use5",   5,1, 2,1, 0,0,0,0, 0, 2'b00, 2'b10);
    // r7, an unrelated instruction, then Rt=r7 -> forward from WB
    ins("w7",     0,0, 0,0, 7,1,0,0, 0, 2'b10, 2'b10);
    ins("gap",    1,1, 2,1, 0,0,0,0, 0, 2'b10, 2'b10);
    ins("use7",   0,0, 7,1, 0,0,0,0, 0, 2'b10, 2'b01);
    // two writers of r7 back to back: the younger one wins
    ins("w7a",    0,0, 0,0, 7,1,0,0, 0, 2'b10, 2'b10);
    ins("w7b",    0,0, 0,0, 7,1,0,0, 0, 2'b10, 2'b10);
    ins("use7b",  0,0, 7,1, 0,0,0,0, 0, 2'b10, 2'b00);
    // load-use: one stall cycle that bubbles EX, then WB forward
    ins("ld3",    0,0, 0,0, 3,1,1,0, 0, 2'b10, 2'b10);
    ins("use3s",  3,1, 0,0, 0,0,0,0, 1, 2'b10, 2'b10);
    ins("use3",   3,1, 0,0, 0,0,0,0, 0, 2'b01, 2'b10);
    // register 0 never matches
    ins("w0",     0,0, 0,0, 0,1,0,0, 0, 2'b10, 2'b10);
    ins("use0",   0,1, 0,1, 0,0,0,0, 0, 2'b10, 2'b10);
    // a flushed load leaves no tag behind
    ins("ld4fl",  0,0, 0,0, 4,1,1,1, 0, 2'b10, 2'b10);
    ins("use4",   4,1, 0,0, 0,0,0,0, 0, 2'b10, 2'b10);
    // stall and flush together: bubble, and Stall still reported
    ins("ld8",    0,0, 0,0, 8,1,1,0, 0, 2'b10, 2'b10);
    ins("use8sf", 0,0, 8,1, 0,0,0,1, 1, 2'b10, 2'b10);
    ins("use8",   0,0, 8,1, 0,0,0,0, 0, 2'b10, 2'b01);
    // a producer that was not read (Use bit low) is ignored
    ins("w9",     0,0, 0,0, 9,1,0,0, 0, 2'b10, 2'b10);
    ins("nouse9", 9,0, 9,0, 0,0,0,0, 0, 2'b10, 2'b10);
`else
    // interlock-only: ALU r5 then its consumer stalls 2 cycles
    ins("alu5",   0,0, 0,0, 5,1,0,0, 0, 2'b10, 2'b10);
    ins("use5s1", 5,1, 0,0, 0,0,0,0, 1, 2'b10, 2'b10);
    ins("use5s2", 5,1, 0,0, 0,0,0,0, 1, 2'b10, 2'b10);
    ins("use5",   5,1, 0,0, 0,0,0,0, 0, 2'b10, 2'b10);
    // a producer that sits only in MEM still stalls (via Rt)
    ins("w9",     0,0, 0,0, 9,1,0,0, 0, 2'b10, 2'b10);
    ins("gap",    1,1, 2,1, 0,0,0,0, 0, 2'b10, 2'b10);
    ins("use9s",  0,0, 9,1, 0,0,0,0, 1, 2'b10, 2'b10);
    ins("use9",   0,0, 9,1, 0,0,0,0, 0, 2'b10, 2'b10);
    // register 0 never matches
    ins("w0",     0,0, 0,0, 0,1,0,0, 0, 2'b10, 2'b10);
    ins("use0",   0,1, 0,1, 0,0,0,0, 0, 2'b10, 2'b10);
    // a flushed writer leaves no tag behind
    ins("w7fl",   0,0, 0,0, 7,1,0,1, 0, 2'b10, 2'b10);
    ins("use7",   0,0, 7,1, 0,0,0,0, 0, 2'b10, 2'b10);
    // a producer that was not read (Use bit low) is ignored
    ins("w10",    0,0, 0,0, 10,1,0,0, 0, 2'b10, 2'b10);
    ins("nouse",  10,0, 10,0, 0,0,0,0, 0, 2'b10, 2'b10);
    idle("drain");
    // stall and flush together: Stall is still reported
    ins("w11",    0,0, 0,0, 11,1,0,0, 0, 2'b10, 2'b10);
    ins("use11sf",11,1, 0,0, 0,0,0,1, 1, 2'b10, 2'b10);
    idle("drain2");
    idle("drain3");
`endif

    reset_mid_stall();
    idle("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Forwarding and load-use hazard unit for the 5-stage pipeline. It sits in the ID stage and tracks the destination tags of the instructions in EXE, MEM and WB. It produces the registered `FwdA`/`FwdB` selects consumed by the EXE-stage operand muxes, and the `Stall` request consumed by the PC and IF/ID registers. It holds its own shadow pipeline of destination tags, advanced in lockstep with the datapath pipeline registers.

## Interface
- Parameters:
- `REG_AW`, 5, register-address width.
- Ports:
- `Clk` input 1: single clock; all state updates on the rising edge.
- `Reset` input 1: synchronous, active-high.
- `ID_Rs` input REG_AW: source register A of the instruction in ID.
- `ID_Rt` input REG_AW: source register B of the instruction in ID.
- `ID_UseRs` input 1: ID instruction reads Rs.
- `ID_UseRt` input 1: ID instruction reads Rt.
- `ID_Rw` input REG_AW: destination register of the ID instruction.
- `ID_RegWr` input 1: ID instruction writes the register file.
- `ID_MemToReg` input 1: ID instruction is a load.
- `ID_Flush` input 1: kill the ID instruction (branch taken); it is replaced by a bubble.
- `Stall` output 1: combinational; holds PC and IF/ID, and inserts a bubble into EXE.
- `FwdA` output 2: registered EXE-stage select for operand A.
- `FwdB` output 2: registered EXE-stage select for operand B.

## Operation
- Fwd encoding:
  - 2'b00: MEM_Result.
  - 2'b01: WB_BusW.
  - 2'b10: EXE_BusA/EXE_BusB (no forward).
  - 2'b11: never driven.
- Shadow tags: each of EX, MEM and WB holds {RegWr, Rw, MemToReg}.
- Tag advance every cycle:
  - WB ← MEM.
  - MEM ← EX.
  - EX ← ID values, or a bubble (RegWr=0) when `Stall` or `ID_Flush` is high.
- Match rule: a stage matches source `r` when the stage RegWr=1, the stage Rw==r, r!=0, and the corresponding Use bit=1.
- Register 0 never matches.
- Load-use: `Stall`=1 when the EX tag has MemToReg=1 and matches Rs or Rt.
- Forward priority, evaluated in ID and registered into EXE (for each source, when not stalling):
  - EX-tag match → 00. That instruction will be in MEM when this one is in EXE.
  - Else MEM-tag match → 01.
  - Else 10.
- The WB-tag producer is covered by register-file write-before-read. The unit does not forward from it.
- Bubble: when `Stall` or `ID_Flush` is high, the registered FwdA/FwdB load 10.
- `Stall` and `ID_Flush` both high: bubble inserted; `Stall` is still asserted as computed.

## Timing
- Reset: all tag RegWr=0, MemToReg=0, Rw=0; FwdA=FwdB=2'b10; `Stall`=0 (tags empty).
- FwdA/FwdB change only on a `Clk` edge. They are valid for the full EXE cycle of the instruction they belong to, with 1-cycle latency from ID.
- `Stall` is combinational from the ID inputs and the EX tag. It has no registered delay.
- A load-use stall lasts exactly 1 cycle. The next cycle the load sits in MEM, and the dependent instruction gets 01 in EXE.
- Reset asserted mid-stall: the next cycle, `Stall`=0 and all tags are cleared. No residual forward.
- Back-to-back writers to the same Rw: the youngest (EX tag) wins.

## Configuration
- `FORWARDING_EN` defined: behaviour as above.
- `FORWARDING_EN` undefined (interlock-only):
  - FwdA/FwdB are held at 10.
  - `Stall`=1 whenever the EX or MEM tag matches Rs or Rt (any writer, not only loads).
  - The dependent instruction waits up to 2 cycles.
  - Bubble insertion is unchanged.

## Test plan
- Reset high 2 cycles → FwdA=FwdB=10, `Stall`=0; after release with idle ID inputs, the outputs stay at those values.
- ALU write r5, then an instruction using Rs=r5 next cycle → FwdA=00 in its EXE cycle, FwdB=10, no stall.
- Writer r7, one unrelated instruction, then Rt=r7 → FwdB=01; writer r7 followed by writer r7 then Rt=r7 → FwdB=00.
- Load r3, then Rs=r3 → `Stall`=1 for exactly one cycle, bubble gives FwdA=10, then FwdA=01 for the dependent instruction.
- Writer with Rw=0, then Rs=0 → FwdA=10, `Stall`=0; load r4 with `ID_Flush`=1 then Rs=r4 → no stall, FwdA=10.
- `FORWARDING_EN` off: ALU r5 then Rs=r5 → `Stall` high 2 cycles, FwdA=10 throughout.
